// File: rtl/digdug_intc_pkg.sv
// rtl/digdug_intc_pkg.sv - shared state types and default timing for the DigDug CPU interrupt front end
package digdug_intc_pkg;

  localparam int NMI_PULSE_DEF   = 8;
  localparam int RESET_HOLD_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    INT_S_IDLE    = 2'd0,
    INT_S_ASSERT  = 2'd1,
    INT_S_ACKING  = 2'd2,
    INT_S_RELEASE = 2'd3
  } int_state_t;

  typedef enum logic [1:0] {
    NMI_S_IDLE    = 2'd0,
    NMI_S_PULSE   = 2'd1,
    NMI_S_WAITLOW = 2'd2
  } nmi_state_t;

endpackage

// File: rtl/digdug_intc_sync.sv
// rtl/digdug_intc_sync.sv - N-stage single-bit synchroniser, async reset to 0
module digdug_intc_sync #(
  parameter int STAGES = 2
) (
  input  logic clkdiv,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/digdug_cpu_intc.sv
// rtl/digdug_cpu_intc.sv - per-CPU /RESET, /INT, /NMI front end with acknowledge vector
// DIGDUG_INTC_VECTOR_EN: drive VECTOR on the read mux during acknowledge; otherwise DV=0, DO=FF (IM1).
module digdug_cpu_intc
  import digdug_intc_pkg::*;
#(
  parameter int          NMI_PULSE   = NMI_PULSE_DEF,
  parameter int          RESET_HOLD  = RESET_HOLD_DEF,
  parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [7:0]  VECTOR      = 8'hFF
) (
  input  logic       clkdiv,
  input  logic       RESET,
  input  logic       RSTREQ,
  input  logic       IRQREQ,
  input  logic       NMIREQ,
  input  logic       M1_N,
  input  logic       IORQ_N,
  output logic       CPU_RESET_N,
  output logic       INT_N,
  output logic       NMI_N,
  output logic       ACK,
  output logic       DV,
  output logic [7:0] DO
);

  logic rs, is, ns;

  digdug_intc_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (.clkdiv(clkdiv), .RESET(RESET), .din(RSTREQ), .dout(rs));
  digdug_intc_sync #(.STAGES(SYNC_STAGES)) u_sync_irq (.clkdiv(clkdiv), .RESET(RESET), .din(IRQREQ), .dout(is));
  digdug_intc_sync #(.STAGES(SYNC_STAGES)) u_sync_nmi (.clkdiv(clkdiv), .RESET(RESET), .din(NMIREQ), .dout(ns));

  logic [7:0] hold_q, hold_d;
  logic       cpu_reset_n_q, cpu_reset_n_d;
  int_state_t int_q, int_d;
  logic       ack_q, ack_d;
  nmi_state_t nmi_q, nmi_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       ns_prev_q, ns_prev_d;
  logic       nedge_q, nedge_d;
  logic       force_idle;

  always_comb begin
    hold_d = hold_q;
    if (rs)                  hold_d = 8'(RESET_HOLD);
    else if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
    cpu_reset_n_d = !(rs || (hold_q != 8'd0));
    // Idle the FSMs on the same edge /RESET falls so no pin glitches through.
    force_idle = !cpu_reset_n_d;
  end

  always_comb begin
    int_d = int_q;
    ack_d = 1'b0;
    case (int_q)
      INT_S_IDLE:    if (is) int_d = INT_S_ASSERT;
      INT_S_ASSERT: begin
        if (!is) begin
          int_d = INT_S_IDLE;
        end else if (!M1_N && !IORQ_N) begin
          int_d = INT_S_ACKING;
          ack_d = 1'b1;
        end
      end
      INT_S_ACKING:  if (IORQ_N) int_d = INT_S_RELEASE;
      INT_S_RELEASE: int_d = is ? INT_S_ASSERT : INT_S_IDLE;
      default:       int_d = INT_S_IDLE;
    endcase
    if (force_idle) begin
      int_d = INT_S_IDLE;
      ack_d = 1'b0;
    end
  end

  always_comb begin
    ns_prev_d = ns;
    nedge_d   = ns && !ns_prev_q;
    nmi_d     = nmi_q;
    pcnt_d    = pcnt_q;
    case (nmi_q)
      NMI_S_IDLE: begin
        if (nedge_q) begin
          nmi_d  = NMI_S_PULSE;
          pcnt_d = 8'(NMI_PULSE);
        end
      end
      NMI_S_PULSE: begin
        pcnt_d = pcnt_q - 8'd1;
        if (pcnt_q == 8'd1) nmi_d = NMI_S_WAITLOW;
      end
      NMI_S_WAITLOW: if (!ns) nmi_d = NMI_S_IDLE;
      default:       nmi_d = NMI_S_IDLE;
    endcase
    if (force_idle) nmi_d = NMI_S_IDLE;
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      hold_q        <= 8'(RESET_HOLD);
      cpu_reset_n_q <= 1'b0;
      int_q         <= INT_S_IDLE;
      ack_q         <= 1'b0;
      nmi_q         <= NMI_S_IDLE;
      pcnt_q        <= 8'd0;
      ns_prev_q     <= 1'b0;
      nedge_q       <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      int_q         <= int_d;
      ack_q         <= ack_d;
      nmi_q         <= nmi_d;
      pcnt_q        <= pcnt_d;
      ns_prev_q     <= ns_prev_d;
      nedge_q       <= nedge_d;
    end
  end

  assign CPU_RESET_N = cpu_reset_n_q;
  assign INT_N       = !((int_q == INT_S_ASSERT) || (int_q == INT_S_ACKING));
  assign NMI_N       = (nmi_q != NMI_S_PULSE);
  assign ACK         = ack_q;

`ifdef DIGDUG_INTC_VECTOR_EN
  assign DV = (int_q == INT_S_ACKING);
  assign DO = DV ? VECTOR : 8'hFF;
`else
  logic unused_vector;
  assign unused_vector = ^VECTOR;
  assign DV = 1'b0;
  assign DO = 8'hFF;
`endif

endmodule

// File: tb/tb_digdug_cpu_intc.sv
// tb/tb_digdug_cpu_intc.sv - directed self-checking bench for digdug_cpu_intc
module tb_digdug_cpu_intc;

  logic       clkdiv = 1'b0;
  logic       RESET  = 1'b1;
  logic       RSTREQ = 1'b0;
  logic       IRQREQ = 1'b0;
  logic       NMIREQ = 1'b0;
  logic       M1_N   = 1'b1;
  logic       IORQ_N = 1'b1;
  logic       CPU_RESET_N, INT_N, NMI_N, ACK, DV;
  logic [7:0] DO;

  int checks   = 0;
  int failures = 0;

`ifdef DIGDUG_INTC_VECTOR_EN
  localparam logic       EXP_DV = 1'b1;
  localparam logic [7:0] EXP_DO = 8'hA5;
`else
  localparam logic       EXP_DV = 1'b0;
  localparam logic [7:0] EXP_DO = 8'hFF;
`endif

  digdug_cpu_intc #(.NMI_PULSE(8), .RESET_HOLD(16), .SYNC_STAGES(2), .VECTOR(8'hA5)) dut (
    .clkdiv(clkdiv), .RESET(RESET), .RSTREQ(RSTREQ), .IRQREQ(IRQREQ), .NMIREQ(NMIREQ),
    .M1_N(M1_N), .IORQ_N(IORQ_N), .CPU_RESET_N(CPU_RESET_N), .INT_N(INT_N), .NMI_N(NMI_N),
    .ACK(ACK), .DV(DV), .DO(DO)
  );

  always #5 clkdiv = ~clkdiv;

  task automatic tick();
    @(posedge clkdiv);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return INT_N;
      1:       return NMI_N;
      default: return CPU_RESET_N;
    endcase
  endfunction

  // Ticks until the selected pin reaches val; n = -1 if the budget runs out.
  task automatic wait_pin(input int which, input logic val, input int maxn, output int n);
    n = -1;
    for (int i = 1; i <= maxn; i++) begin
      tick();
      if (pick(which) === val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, lows, falls, acks, bad;
    logic prev;

    // Reset state
    #12;
    check("rst_cpu_reset_n", CPU_RESET_N, 0);
    check("rst_int_n", INT_N, 1);
    check("rst_nmi_n", NMI_N, 1);
    check("rst_ack", ACK, 0);
    check("rst_dv", DV, 0);
    check("rst_do", DO, 8'hFF);

    // Reset release: RSTREQ high 5 clocks, CPU_RESET_N rises 19 clocks after the fall
    @(posedge clkdiv); #1;
    RESET = 1'b0;
    RSTREQ = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (CPU_RESET_N !== 1'b0 || INT_N !== 1'b1 || NMI_N !== 1'b1) bad++;
    end
    RSTREQ = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (INT_N !== 1'b1 || NMI_N !== 1'b1) bad++;
      if (CPU_RESET_N === 1'b1) begin
        n = i;
        break;
      end
    end
    check("release_latency", n, 19);
    check("release_pins_quiet", bad, 0);

    // Interrupt acknowledge
    IRQREQ = 1'b1;
    wait_pin(0, 1'b0, 10, n);
    check("int_latency", n, 3);
    M1_N = 1'b0; IORQ_N = 1'b0;
    tick();
    check("ack_c1_ack", ACK, 1);
    check("ack_c1_dv", DV, EXP_DV);
    check("ack_c1_do", DO, EXP_DO);
    check("ack_c1_int_n", INT_N, 0);
    tick();
    check("ack_c2_ack", ACK, 0);
    check("ack_c2_dv", DV, EXP_DV);
    check("ack_c2_do", DO, EXP_DO);
    tick();
    check("ack_c3_ack", ACK, 0);
    check("ack_c3_dv", DV, EXP_DV);
    check("ack_c3_do", DO, EXP_DO);
    M1_N = 1'b1; IORQ_N = 1'b1;
    tick();
    check("release_int_n", INT_N, 1);
    check("release_dv", DV, 0);
    check("release_do", DO, 8'hFF);
    check("release_ack", ACK, 0);
    tick();
    check("reassert_int_n", INT_N, 0);
    check("reassert_ack", ACK, 0);
    IRQREQ = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("irq_drop_int_n", INT_N, 1);

    // Withdrawn request: 4-clock IRQREQ pulse, no acknowledge
    IRQREQ = 1'b1;
    lows = 0; acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 3) IRQREQ = 1'b0;
      if (INT_N === 1'b0) lows++;
      if (ACK === 1'b1) acks++;
    end
    check("withdraw_low_clocks", lows, 4);
    check("withdraw_acks", acks, 0);

    // Held NMI: one 8-clock pulse, then a second rise gives a second pulse
    NMIREQ = 1'b1;
    wait_pin(1, 1'b0, 10, n);
    check("nmi_latency", n, 4);
    lows = 1; falls = 1; prev = 1'b0;
    for (int i = 0; i < 96; i++) begin
      tick();
      if (NMI_N === 1'b0) lows++;
      if (prev === 1'b1 && NMI_N === 1'b0) falls++;
      prev = NMI_N;
    end
    check("nmi_held_low_clocks", lows, 8);
    check("nmi_held_pulses", falls, 1);
    NMIREQ = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    NMIREQ = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (NMI_N === 1'b0) lows++;
    end
    check("nmi_second_low_clocks", lows, 8);
    NMIREQ = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset during ACKING
    IRQREQ = 1'b1;
    wait_pin(0, 1'b0, 10, n);
    check("mid_ack_int_latency", n, 3);
    M1_N = 1'b0; IORQ_N = 1'b0;
    tick();
    check("mid_ack_dv", DV, EXP_DV);
    RSTREQ = 1'b1;
    wait_pin(2, 1'b0, 10, n);
    check("mid_ack_reset_latency", n, 3);
    check("mid_ack_dv_off", DV, 0);
    check("mid_ack_do_off", DO, 8'hFF);
    check("mid_ack_ack_off", ACK, 0);
    check("mid_ack_int_n", INT_N, 1);
    IRQREQ = 1'b0; M1_N = 1'b1; IORQ_N = 1'b1;
    RSTREQ = 1'b0;
    wait_pin(2, 1'b1, 40, n);
    check("mid_ack_release", n, 19);

    // Reset during an NMI pulse, request held through release
    NMIREQ = 1'b1;
    wait_pin(1, 1'b0, 10, n);
    check("mid_nmi_latency", n, 4);
    tick(); tick();
    RSTREQ = 1'b1;
    wait_pin(2, 1'b0, 10, n);
    check("mid_nmi_reset_latency", n, 3);
    check("mid_nmi_nmi_n", NMI_N, 1);
    RSTREQ = 1'b0;
    wait_pin(2, 1'b1, 40, n);
    check("mid_nmi_release", n, 19);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (NMI_N === 1'b0) lows++;
    end
    check("mid_nmi_no_resume", lows, 0);
    NMIREQ = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
